// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the I/D memory port arbiter
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_RESP  = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } arb_owner_t;

   // Wide enough for the largest legal starvation limit (255).
   localparam int STARVE_W = 8;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// rtl/mem_port_arbiter_starve_ctr.sv - saturating count of D grants taken while I waits
module arb_starve_ctr
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_STARVE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   localparam logic [STARVE_W-1:0] MAX_CNT = STARVE_W'(MAX_STARVE);

   logic [STARVE_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != MAX_CNT)) begin
         count <= count + 1'b1;
      end
   end

   assign at_max = (count == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding arbiter sharing one memory port between I and D
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 128,
   parameter int MAX_STARVE = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_req_valid,
   output logic                i_req_ready,
   input  logic [ADDR_W-1:0]   i_req_addr,
   output logic                i_resp_valid,
   output logic [DATA_W-1:0]   i_resp_data,
   input  logic                d_req_valid,
   output logic                d_req_ready,
   input  logic [ADDR_W-1:0]   d_req_addr,
   input  logic                d_req_we,
   input  logic [DATA_W-1:0]   d_req_wdata,
   input  logic [DATA_W/8-1:0] d_req_wmask,
   output logic                d_resp_valid,
   output logic [DATA_W-1:0]   d_resp_data,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic                mem_req_we,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_resp_data,
   output logic                proto_err
);

   arb_state_t state;
   arb_owner_t owner;

   logic grant_i;
   logic grant_d;
   logic starve_inc;
   logic starve_at_max;

   // D normally wins; I is forced once D has been favoured MAX_STARVE times in a row.
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (!reset && (state == ARB_IDLE)) begin
         if (d_req_valid && !(i_req_valid && starve_at_max)) begin
            grant_d = 1'b1;
         end else if (i_req_valid) begin
            grant_i = 1'b1;
         end
      end
   end

   assign i_req_ready = grant_i;
   assign d_req_ready = grant_d;
   assign starve_inc  = grant_d && i_req_valid;

   arb_starve_ctr #(
      .MAX_STARVE (MAX_STARVE)
   ) u_starve (
      .clk    (clk),
      .reset  (reset),
      .inc    (starve_inc),
      .clr    (grant_i),
      .at_max (starve_at_max)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ARB_IDLE;
         owner         <= OWN_NONE;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_we    <= 1'b0;
         mem_req_wdata <= '0;
         mem_req_wmask <= '0;
         proto_err     <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (mem_resp_valid) begin
                  proto_err <= 1'b1;
               end
               if (grant_d) begin
                  owner         <= OWN_D;
                  mem_req_valid <= 1'b1;
                  mem_req_addr  <= d_req_addr;
                  mem_req_we    <= d_req_we;
                  mem_req_wdata <= d_req_wdata;
                  mem_req_wmask <= d_req_wmask;
                  state         <= ARB_ISSUE;
               end else if (grant_i) begin
                  owner         <= OWN_I;
                  mem_req_valid <= 1'b1;
                  mem_req_addr  <= i_req_addr;
                  mem_req_we    <= 1'b0;
                  mem_req_wdata <= '0;
                  mem_req_wmask <= '0;
                  state         <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               // A response before the request is accepted is flagged and dropped.
               if (mem_resp_valid) begin
                  proto_err <= 1'b1;
               end
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= ARB_RESP;
               end
            end
            ARB_RESP: begin
               if (mem_resp_valid) begin
                  owner <= OWN_NONE;
                  state <= ARB_IDLE;
               end
            end
            default: begin
               owner         <= OWN_NONE;
               mem_req_valid <= 1'b0;
               state         <= ARB_IDLE;
            end
         endcase
      end
   end

   assign i_resp_valid = (state == ARB_RESP) && (owner == OWN_I) && mem_resp_valid;
   assign d_resp_valid = (state == ARB_RESP) && (owner == OWN_D) && mem_resp_valid;
   assign i_resp_data  = i_resp_valid ? mem_resp_data : '0;
   assign d_resp_data  = d_resp_valid ? mem_resp_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 128;
   localparam int MAX_STARVE = 4;

   logic                clk = 1'b0;
   logic                reset;
   logic                i_req_valid;
   logic                i_req_ready;
   logic [ADDR_W-1:0]   i_req_addr;
   logic                i_resp_valid;
   logic [DATA_W-1:0]   i_resp_data;
   logic                d_req_valid;
   logic                d_req_ready;
   logic [ADDR_W-1:0]   d_req_addr;
   logic                d_req_we;
   logic [DATA_W-1:0]   d_req_wdata;
   logic [DATA_W/8-1:0] d_req_wmask;
   logic                d_resp_valid;
   logic [DATA_W-1:0]   d_resp_data;
   logic                mem_req_valid;
   logic                mem_req_ready;
   logic [ADDR_W-1:0]   mem_req_addr;
   logic                mem_req_we;
   logic [DATA_W-1:0]   mem_req_wdata;
   logic [DATA_W/8-1:0] mem_req_wmask;
   logic                mem_resp_valid;
   logic [DATA_W-1:0]   mem_resp_data;
   logic                proto_err;

   mem_port_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .MAX_STARVE (MAX_STARVE)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .i_req_valid    (i_req_valid),
      .i_req_ready    (i_req_ready),
      .i_req_addr     (i_req_addr),
      .i_resp_valid   (i_resp_valid),
      .i_resp_data    (i_resp_data),
      .d_req_valid    (d_req_valid),
      .d_req_ready    (d_req_ready),
      .d_req_addr     (d_req_addr),
      .d_req_we       (d_req_we),
      .d_req_wdata    (d_req_wdata),
      .d_req_wmask    (d_req_wmask),
      .d_resp_valid   (d_resp_valid),
      .d_resp_data    (d_resp_data),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_req_we     (mem_req_we),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wmask  (mem_req_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .proto_err      (proto_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // transaction-level model: one outstanding request, accepted or not yet accepted
   bit                  m_busy, m_acc, m_perr;
   int                  m_owner;
   int                  m_starve;
   logic [ADDR_W-1:0]   m_addr;
   logic                m_we;
   logic [DATA_W-1:0]   m_wdata;
   logic [DATA_W/8-1:0] m_wmask;

   // observation log kept by the compare loop
   string               glog;
   int                  cyc, i_resp_cnt, d_resp_cnt, mv_cnt;
   int                  i_grant_cyc, d_grant_cyc, d_resp_cyc;
   bit                  i_rdy_seen, d_rdy_seen;
   logic [DATA_W-1:0]   last_i_resp_data;

   bit                  auto_mem, mem_pend;
   logic [31:0]         resp_word;

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int win;
      bit exp_mv, exp_ir, exp_dr;
      win = 0;
      if (!reset && !m_busy) begin
         if (d_req_valid && !(i_req_valid && m_starve == MAX_STARVE)) win = 2;
         else if (i_req_valid) win = 1;
      end
      exp_mv = !reset && m_busy && !m_acc;
      exp_ir = !reset && m_busy && m_acc && (m_owner == 1) && mem_resp_valid;
      exp_dr = !reset && m_busy && m_acc && (m_owner == 2) && mem_resp_valid;
      chk("i_req_ready", i_req_ready, (win == 1));
      chk("d_req_ready", d_req_ready, (win == 2));
      chk("mem_req_valid", mem_req_valid, exp_mv);
      chk("i_resp_valid", i_resp_valid, exp_ir);
      chk("d_resp_valid", d_resp_valid, exp_dr);
      chk("proto_err", proto_err, !reset && m_perr);
      if (exp_mv) begin
         chk("mem_req_addr", mem_req_addr, m_addr);
         chk("mem_req_we", mem_req_we, m_we);
         chk("mem_req_wdata", mem_req_wdata, m_wdata);
         chk("mem_req_wmask", mem_req_wmask, m_wmask);
      end
      if (exp_ir) chk("i_resp_data", i_resp_data, mem_resp_data);
      if (exp_dr) chk("d_resp_data", d_resp_data, mem_resp_data);

      cyc++;
      i_rdy_seen = i_req_ready;
      d_rdy_seen = d_req_ready;
      if (i_req_ready) begin glog = {glog, "I"}; i_grant_cyc = cyc; end
      if (d_req_ready) begin glog = {glog, "D"}; d_grant_cyc = cyc; end
      if (mem_req_valid) mv_cnt++;
      if (i_resp_valid) begin i_resp_cnt++; last_i_resp_data = i_resp_data; end
      if (d_resp_valid) begin d_resp_cnt++; d_resp_cyc = cyc; end

      if (reset) begin
         m_busy = 0; m_acc = 0; m_perr = 0; m_owner = 0; m_starve = 0;
      end else begin
         if ((!m_busy || !m_acc) && mem_resp_valid) m_perr = 1;
         if (win == 2) begin
            m_busy = 1; m_acc = 0; m_owner = 2;
            m_addr = d_req_addr; m_we = d_req_we; m_wdata = d_req_wdata; m_wmask = d_req_wmask;
            if (i_req_valid && m_starve < MAX_STARVE) m_starve++;
         end else if (win == 1) begin
            m_busy = 1; m_acc = 0; m_owner = 1;
            m_addr = i_req_addr; m_we = 0; m_wdata = '0; m_wmask = '0;
            m_starve = 0;
         end else if (m_busy && !m_acc && mem_req_ready) begin
            m_acc = 1;
         end else if (m_busy && m_acc && mem_resp_valid) begin
            m_busy = 0; m_owner = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (auto_mem) begin
         mem_req_ready = 0;
         mem_resp_valid = 0;
         if (mem_pend) begin
            mem_resp_valid = 1;
            mem_resp_data = {4{resp_word}};
            resp_word = resp_word + 1;
            mem_pend = 0;
         end else if (mem_req_valid) begin
            mem_req_ready = 1;
            mem_pend = 1;
         end
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic wait_grant(input bit is_d, input string name);
      bit ok;
      ok = 0;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (is_d ? d_rdy_seen : i_rdy_seen) begin
            ok = 1;
            break;
         end
      end
      chk(name, ok, 1);
   endtask

   task automatic do_reset();
      reset = 1;
      i_req_valid = 0; d_req_valid = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
      auto_mem = 0; mem_pend = 0;
      ticks(2);
      reset = 0;
   endtask

   initial begin
      reset = 1;
      i_req_valid = 0; i_req_addr = '0;
      d_req_valid = 0; d_req_addr = '0; d_req_we = 0; d_req_wdata = '0; d_req_wmask = '0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
      auto_mem = 0; mem_pend = 0; resp_word = 32'h1000_0000;
      glog = "";
      fork
         forever begin
            @(negedge clk);
            model_step();
         end
      join_none

      // reset state
      ticks(2);
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_mem_req_addr", mem_req_addr, 0);
      chk("rst_mem_req_wdata", mem_req_wdata, 0);
      chk("rst_proto_err", proto_err, 0);
      reset = 0;
      tick();

      // single I read with fixed timing
      i_resp_cnt = 0; d_resp_cnt = 0;
      i_req_valid = 1; i_req_addr = 32'h1000;
      tick();
      chk("t1_i_ready_at_T", i_rdy_seen, 1);
      chk("t1_mem_addr", mem_req_addr, 32'h1000);
      chk("t1_mem_we", mem_req_we, 0);
      i_req_valid = 0;
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      ticks(2);
      mem_resp_valid = 1; mem_resp_data = {16{8'hA5}};
      tick();
      mem_resp_valid = 0;
      tick();
      chk("t1_i_resp_cnt", i_resp_cnt, 1);
      chk("t1_i_resp_data", last_i_resp_data, {16{8'hA5}});
      chk("t1_d_resp_cnt", d_resp_cnt, 0);

      // D write with delayed acceptance and a queued second request
      d_req_valid = 1; d_req_addr = 32'h2000; d_req_we = 1;
      d_req_wdata = {4{32'hDEAD_BEEF}}; d_req_wmask = 16'h000F;
      mv_cnt = 0; d_resp_cnt = 0;
      tick();
      chk("t2_d_ready", d_rdy_seen, 1);
      tick();
      tick();
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      chk("t2_mem_valid_cycles", mv_cnt, 3);
      mem_resp_valid = 1; mem_resp_data = '0;
      tick();
      mem_resp_valid = 0;
      tick();
      chk("t2_d_resp_cnt", d_resp_cnt, 1);
      chk("t2_second_grant", d_rdy_seen, 1);
      chk("t2_regrant_gap", d_grant_cyc - d_resp_cyc, 1);
      d_req_valid = 0;
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0; mem_resp_valid = 1;
      tick();
      mem_resp_valid = 0;
      tick();

      // both sides saturating the port
      do_reset();
      auto_mem = 1;
      glog = "";
      i_req_valid = 1; i_req_addr = 32'h4000;
      d_req_valid = 1; d_req_addr = 32'h5000; d_req_we = 0; d_req_wmask = '0;
      for (int n = 0; n < 200 && glog.len() < 10; n++) tick();
      i_req_valid = 0; d_req_valid = 0;
      ticks(4);
      chk("t3_grant_seq", (glog == "DDDDIDDDDI"), 1);

      // stray response in IDLE is sticky
      do_reset();
      mem_resp_valid = 1;
      tick();
      mem_resp_valid = 0;
      tick();
      chk("t4_proto_set", proto_err, 1);
      auto_mem = 1;
      d_resp_cnt = 0;
      d_req_valid = 1; d_req_addr = 32'h6000; d_req_we = 0;
      wait_grant(1, "t4_d_grant");
      d_req_valid = 0;
      ticks(4);
      chk("t4_d_resp_cnt", d_resp_cnt, 1);
      chk("t4_proto_held", proto_err, 1);

      // accept and respond in the same ISSUE cycle
      do_reset();
      chk("t5_proto_cleared", proto_err, 0);
      d_resp_cnt = 0;
      d_req_valid = 1; d_req_addr = 32'h7000;
      tick();
      d_req_valid = 0;
      mem_req_ready = 1; mem_resp_valid = 1;
      tick();
      mem_req_ready = 0; mem_resp_valid = 0;
      tick();
      chk("t5_proto_set", proto_err, 1);
      chk("t5_resp_dropped", d_resp_cnt, 0);
      mem_resp_valid = 1;
      tick();
      mem_resp_valid = 0;
      tick();
      chk("t5_d_resp_cnt", d_resp_cnt, 1);

      // reset during RESP with D owning
      do_reset();
      d_req_valid = 1; d_req_addr = 32'h8000; d_req_we = 1; d_req_wmask = 16'hFFFF;
      tick();
      d_req_valid = 0;
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      reset = 1; i_req_valid = 1; i_req_addr = 32'h3000; mem_resp_valid = 1;
      #1;
      chk("t6_d_resp_valid", d_resp_valid, 0);
      chk("t6_i_req_ready", i_req_ready, 0);
      chk("t6_mem_req_valid", mem_req_valid, 0);
      chk("t6_mem_req_addr", mem_req_addr, 0);
      chk("t6_mem_req_wmask", mem_req_wmask, 0);
      tick();
      reset = 0; mem_resp_valid = 0; mem_pend = 0; auto_mem = 1;
      i_resp_cnt = 0;
      wait_grant(0, "t6_i_grant");
      i_req_valid = 0;
      ticks(4);
      chk("t6_i_resp_cnt", i_resp_cnt, 1);
      chk("t6_proto_err", proto_err, 0);

      // I arrives just after a lone D grant
      do_reset();
      auto_mem = 1;
      glog = "";
      d_req_valid = 1; d_req_addr = 32'h9000; d_req_we = 0;
      tick();
      chk("t7_d_ready", d_rdy_seen, 1);
      d_req_valid = 0;
      i_req_valid = 1; i_req_addr = 32'hA000;
      wait_grant(0, "t7_i_grant");
      i_req_valid = 0;
      ticks(4);
      chk("t7_order", (glog == "DI"), 1);
      chk("t7_i_after_d_resp", i_grant_cyc - d_resp_cyc, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
